// File: rtl/wb_burst_initiator.sv
// Wishbone classic-cycle burst initiator: one command becomes cmd_len+1 single-beat
// transfers at consecutive word addresses, each answered on a valid/ready response channel.
module wb_burst_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_adr,
  input  logic [DATA_W/8-1:0]   cmd_sel,
  input  logic [DATA_W-1:0]     cmd_dat,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_dat,
  output logic                  rsp_err,
  output logic                  rsp_last,
  output logic                  busy,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  input  logic [DATA_W-1:0]     wbm_dat_i,
  input  logic                  wbm_ack_i
);

  localparam int SEL_W  = DATA_W / 8;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP, GAP} state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0]  beats_left, beats_left_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic              cmd_ready_nxt, busy_nxt;
  logic              cyc_nxt, stb_nxt, we_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [DATA_W-1:0] dat_o_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_last_nxt;
  logic [DATA_W-1:0] rsp_dat_nxt;

  logic cmd_take, rsp_take, rsp_done, beat_timeout;

  // Word-granular address step; wraps naturally at the top of the address space.
  function automatic logic [ADDR_W-1:0] next_adr(input logic [ADDR_W-1:0] adr);
    return adr + ADDR_W'(SEL_W);
  endfunction

  assign cmd_take     = cmd_valid && cmd_ready;
  assign rsp_take     = rsp_valid && rsp_ready;
  assign rsp_done     = rsp_last || rsp_err;
  assign beat_timeout = !wbm_ack_i && (wait_cnt == WAIT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      beats_left <= '0;
      wait_cnt   <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_err    <= 1'b0;
      rsp_last   <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_left_nxt;
      wait_cnt   <= wait_cnt_nxt;
      cmd_ready  <= cmd_ready_nxt;
      busy       <= busy_nxt;
      wbm_cyc_o  <= cyc_nxt;
      wbm_stb_o  <= stb_nxt;
      wbm_we_o   <= we_nxt;
      wbm_sel_o  <= sel_nxt;
      wbm_adr_o  <= adr_nxt;
      wbm_dat_o  <= dat_o_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_dat    <= rsp_dat_nxt;
      rsp_err    <= rsp_err_nxt;
      rsp_last   <= rsp_last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_take) state_nxt = REQ;
      REQ:     if (wbm_ack_i || beat_timeout) state_nxt = RSP;
      RSP:     if (rsp_take) state_nxt = rsp_done ? IDLE : GAP;
      GAP:     state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is registered, so this block computes next-cycle values.
  always_comb begin
    beats_left_nxt = beats_left;
    wait_cnt_nxt   = wait_cnt;
    cyc_nxt        = wbm_cyc_o;
    stb_nxt        = wbm_stb_o;
    we_nxt         = wbm_we_o;
    sel_nxt        = wbm_sel_o;
    adr_nxt        = wbm_adr_o;
    dat_o_nxt      = wbm_dat_o;
    rsp_valid_nxt  = rsp_valid;
    rsp_dat_nxt    = rsp_dat;
    rsp_err_nxt    = rsp_err;
    rsp_last_nxt   = rsp_last;
    cmd_ready_nxt  = (state_nxt == IDLE);
    busy_nxt       = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (cmd_take) begin
          we_nxt         = cmd_we;
          sel_nxt        = cmd_sel;
          adr_nxt        = cmd_adr;
          dat_o_nxt      = cmd_dat;
          beats_left_nxt = cmd_len;
          wait_cnt_nxt   = '0;
          cyc_nxt        = 1'b1;
          stb_nxt        = 1'b1;
        end
      end
      REQ: begin
        if (wbm_ack_i) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_dat_nxt   = wbm_we_o ? '0 : wbm_dat_i;
          rsp_err_nxt   = 1'b0;
          rsp_last_nxt  = (beats_left == '0);
        end else if (beat_timeout) begin
          // A silent slave abandons the rest of the burst.
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_dat_nxt   = '0;
          rsp_err_nxt   = 1'b1;
          rsp_last_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      RSP: begin
        if (rsp_take) begin
          rsp_valid_nxt = 1'b0;
          rsp_dat_nxt   = '0;
          rsp_err_nxt   = 1'b0;
          rsp_last_nxt  = 1'b0;
          if (!rsp_done) begin
            beats_left_nxt = beats_left - LEN_W'(1);
            adr_nxt        = next_adr(wbm_adr_o);
            wait_cnt_nxt   = '0;
          end
        end
      end
      GAP: begin
        cyc_nxt = 1'b1;
        stb_nxt = 1'b1;
      end
      default: begin
        cyc_nxt = 1'b0;
        stb_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_burst_initiator.sv
// Bench for wb_burst_initiator: directed and randomized bursts against a beat-level
// model of bus pulses and responses, with a configurable-latency Wishbone responder.
module tb_wb_burst_initiator;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err, rsp_last, busy;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;

  wb_burst_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_sel(cmd_sel), .cmd_dat(cmd_dat), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .rsp_last(rsp_last), .busy(busy),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Responder: acks after slv_delay strobe cycles, read data = address ^ slv_key.
  int          slv_delay = 1;
  bit          slv_never = 1'b0;
  logic [31:0] slv_key   = '0;
  logic        slv_ack   = 1'b0;
  logic [31:0] slv_dat   = '0;
  int          stb_cnt   = 0;

  always @(posedge wb_clk_i) begin
    if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1 && !slv_ack) begin
      stb_cnt <= stb_cnt + 1;
      if (!slv_never && stb_cnt + 1 == slv_delay) begin
        slv_ack <= 1'b1;
        slv_dat <= wbm_adr_o ^ slv_key;
      end
    end else begin
      slv_ack <= 1'b0;
      if (!(wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1)) stb_cnt <= 0;
    end
  end

  assign wbm_ack_i = slv_ack;
  assign wbm_dat_i = slv_dat;

  // Bus and response monitors.
  typedef struct {
    logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; int start; int len;
  } pulse_t;
  typedef struct {
    logic [31:0] dat; logic err; logic last; int rise;
  } rsp_t;

  pulse_t pq[$];
  rsp_t   rq[$];
  pulse_t cur;
  bit     in_pulse = 1'b0;
  int     cnum = 0;
  int     bus_bad = 0, rsp_bad = 0;
  bit     rv_on = 1'b0;
  logic [31:0] rv_dat;
  logic   rv_err, rv_last;
  int     rv_rise;

  function automatic rsp_t mk_rsp(input logic [31:0] d, input logic e, input logic l, input int r);
    rsp_t x;
    x.dat = d; x.err = e; x.last = l; x.rise = r;
    return x;
  endfunction

  always @(posedge wb_clk_i) begin
    cnum <= cnum + 1;
    if (wbm_cyc_o !== wbm_stb_o) bus_bad <= bus_bad + 1;
    if (wbm_stb_o === 1'b1) begin
      if (!in_pulse) begin
        cur.adr <= wbm_adr_o; cur.we <= wbm_we_o; cur.sel <= wbm_sel_o; cur.dat <= wbm_dat_o;
        cur.start <= cnum; cur.len <= 1;
        in_pulse <= 1'b1;
      end else begin
        if ({wbm_adr_o, wbm_we_o, wbm_sel_o, wbm_dat_o} !== {cur.adr, cur.we, cur.sel, cur.dat})
          bus_bad <= bus_bad + 1;
        cur.len <= cur.len + 1;
      end
    end else if (in_pulse) begin
      pq.push_back(cur);
      in_pulse <= 1'b0;
    end
    if (rsp_valid === 1'b1) begin
      if (!rv_on) begin
        rv_dat <= rsp_dat; rv_err <= rsp_err; rv_last <= rsp_last; rv_rise <= cnum;
        rv_on <= 1'b1;
      end else if ({rsp_dat, rsp_err, rsp_last} !== {rv_dat, rv_err, rv_last}) begin
        rsp_bad <= rsp_bad + 1;
      end
      if (rsp_ready === 1'b1) begin
        rq.push_back(mk_rsp(rsp_dat, rsp_err, rsp_last, rv_on ? rv_rise : cnum));
        rv_on <= 1'b0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Current command and its expected beats.
  logic        t_we;
  logic [31:0] t_adr, t_dat;
  logic [3:0]  t_sel, t_len;
  int          t_d;
  logic [31:0] e_adr[$];
  int          e_len[$];
  logic [31:0] e_dat[$];
  logic        e_err[$];
  logic        e_last[$];
  int          bus_bad0, rsp_bad0;

  task automatic prep(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [3:0] len, input int d,
                      input bit never, input logic [31:0] key);
    logic [31:0] a;
    t_we = we; t_adr = adr; t_sel = sel; t_dat = dat; t_len = len; t_d = d;
    slv_delay = d; slv_never = never; slv_key = key;
    e_adr.delete(); e_len.delete(); e_dat.delete(); e_err.delete(); e_last.delete();
    a = adr;
    for (int i = 0; i <= int'(len); i++) begin
      e_adr.push_back(a);
      if (never || d + 1 > TIMEOUT) begin
        e_len.push_back(TIMEOUT); e_dat.push_back(32'h0); e_err.push_back(1'b1); e_last.push_back(1'b1);
        break;
      end
      e_len.push_back(d + 1);
      e_dat.push_back(we ? 32'h0 : (a ^ key));
      e_err.push_back(1'b0);
      e_last.push_back(i == int'(len));
      a = a + 32'd4;
    end
    pq.delete(); rq.delete();
    bus_bad0 = bus_bad; rsp_bad0 = rsp_bad;
  endtask

  task automatic start_cmd(input string tag);
    int n;
    n = 0;
    @(negedge wb_clk_i);
    cmd_valid = 1'b1; cmd_we = t_we; cmd_adr = t_adr; cmd_sel = t_sel; cmd_dat = t_dat; cmd_len = t_len;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk({tag, ".accept_ready"}, cmd_ready, 1);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    chk({tag, ".issue_busy"}, busy, 1);
    chk({tag, ".issue_cmd_ready"}, cmd_ready, 0);
    chk({tag, ".issue_stb"}, {wbm_cyc_o, wbm_stb_o}, 2'b11);
    chk({tag, ".issue_adr"}, wbm_adr_o, t_adr);
  endtask

  task automatic drain(input string tag, input int bp);
    int n, rdy_bad;
    n = 0; rdy_bad = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (cmd_ready !== 1'b0) rdy_bad++;
      cmd_valid = 1'($urandom_range(1));
      cmd_adr   = $urandom;
      cmd_len   = 4'($urandom);
      cmd_we    = 1'($urandom_range(1));
      rsp_ready = ($urandom_range(99) >= bp);
      @(negedge wb_clk_i);
      n++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".cmd_ready_back"}, cmd_ready, 1);
    chk({tag, ".cmd_ready_low_while_busy"}, rdy_bad, 0);
    @(negedge wb_clk_i);
  endtask

  task automatic compare(input string tag, input bit chk_period);
    chk({tag, ".npulse"}, pq.size(), e_adr.size());
    chk({tag, ".nrsp"}, rq.size(), e_dat.size());
    for (int i = 0; i < e_adr.size() && i < pq.size(); i++) begin
      chk($sformatf("%s.adr[%0d]", tag, i), pq[i].adr, e_adr[i]);
      chk($sformatf("%s.we_sel[%0d]", tag, i), {pq[i].we, pq[i].sel}, {t_we, t_sel});
      chk($sformatf("%s.dat_o[%0d]", tag, i), pq[i].dat, t_dat);
      chk($sformatf("%s.stb_len[%0d]", tag, i), pq[i].len, e_len[i]);
      if (chk_period && i > 0)
        chk($sformatf("%s.period[%0d]", tag, i), pq[i].start - pq[i-1].start, t_d + 3);
    end
    for (int i = 0; i < e_dat.size() && i < rq.size(); i++) begin
      chk($sformatf("%s.rsp_dat[%0d]", tag, i), rq[i].dat, e_dat[i]);
      chk($sformatf("%s.rsp_err_last[%0d]", tag, i), {rq[i].err, rq[i].last}, {e_err[i], e_last[i]});
      if (i < pq.size())
        chk($sformatf("%s.ack_to_rsp[%0d]", tag, i), rq[i].rise, pq[i].start + pq[i].len);
    end
    chk({tag, ".bus_stable"}, bus_bad - bus_bad0, 0);
    chk({tag, ".rsp_stable"}, rsp_bad - rsp_bad0, 0);
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input logic [3:0] len, input int d, input bit never,
                     input logic [31:0] key, input int bp, input bit chk_period);
    prep(we, adr, sel, dat, len, d, never, key);
    start_cmd(tag);
    drain(tag, bp);
    compare(tag, chk_period);
  endtask

  task automatic rand_run(input int k);
    logic we;
    int d, bp;
    bit nv;
    we = 1'($urandom_range(1));
    d  = $urandom_range(1, 9);
    nv = ($urandom_range(9) == 0);
    bp = $urandom_range(0, 60);
    run($sformatf("rand%0d", k), we, $urandom, 4'($urandom), $urandom, 4'($urandom_range(0, 7)),
        d, nv, $urandom, bp, 1'b0);
  endtask

  initial begin
    logic [31:0] hold_dat;
    logic [1:0]  hold_el;
    int n;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    chk("reset.cmd_ready", cmd_ready, 0);
    chk("reset.busy_cyc_stb", {busy, wbm_cyc_o, wbm_stb_o}, 3'b000);
    chk("reset.rsp", {rsp_valid, rsp_err, rsp_last}, 3'b000);
    chk("reset.adr", wbm_adr_o, 0);
    chk("reset.rsp_dat", rsp_dat, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("reset.cmd_ready_after", cmd_ready, 1);

    run("single_read", 1'b0, 32'h3000_0000, 4'hF, 32'h0, 4'd0, 1, 1'b0, 32'h2234_5678, 0, 1'b1);
    run("write_burst", 1'b1, 32'h3000_0010, 4'h3, 32'hA5A5_A5A5, 4'd3, 1, 1'b0, 32'h0, 0, 1'b1);

    // Backpressure: first response held, second beat must wait for the handshake
    rsp_ready = 1'b0;
    prep(1'b0, 32'h3000_0040, 4'hF, 32'h0, 4'd1, 2, 1'b0, 32'h0BAD_F00D);
    start_cmd("bp");
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("bp.rsp_valid_seen", rsp_valid, 1);
    chk("bp.first_dat", rsp_dat, 32'h3000_0040 ^ 32'h0BAD_F00D);
    hold_dat = rsp_dat;
    hold_el  = {rsp_err, rsp_last};
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      chk($sformatf("bp.no_stb[%0d]", i), wbm_stb_o, 0);
      chk($sformatf("bp.hold_valid[%0d]", i), rsp_valid, 1);
      chk($sformatf("bp.hold_dat[%0d]", i), rsp_dat, hold_dat);
      chk($sformatf("bp.hold_err_last[%0d]", i), {rsp_err, rsp_last}, hold_el);
    end
    drain("bp", 0);
    compare("bp", 1'b0);

    run("timeout", 1'b0, 32'h3000_0100, 4'hF, 32'h0, 4'd2, 1, 1'b1, 32'h0, 0, 1'b0);
    run("deadline_ack", 1'b0, 32'h3000_0200, 4'hF, 32'h0, 4'd1, TIMEOUT - 1, 1'b0, 32'h1111_2222, 0, 1'b1);
    run("past_deadline", 1'b0, 32'h3000_0300, 4'hF, 32'h0, 4'd1, TIMEOUT, 1'b0, 32'h1111_2222, 0, 1'b0);
    run("wrap", 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 4'd1, 2, 1'b0, 32'h5555_AAAA, 0, 1'b1);

    // Reset while a beat is in flight
    rsp_ready = 1'b1;
    prep(1'b0, 32'h2000_0000, 4'hF, 32'h0, 4'd3, 1, 1'b1, 32'h0);
    start_cmd("rst_mid");
    repeat (2) @(negedge wb_clk_i);
    chk("rst_mid.stb_before", wbm_stb_o, 1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("rst_mid.cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
    chk("rst_mid.rsp_valid", rsp_valid, 0);
    chk("rst_mid.busy_ready", {busy, cmd_ready}, 2'b00);
    chk("rst_mid.adr", wbm_adr_o, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_mid.cmd_ready_after", cmd_ready, 1);
    repeat (20) @(negedge wb_clk_i);
    chk("rst_mid.no_rsp", rq.size(), 0);
    chk("rst_mid.still_idle", {busy, rsp_valid}, 2'b00);

    for (int k = 0; k < 12; k++) rand_run(k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
